// File: rtl/sort_seq_if.sv
// Handshake bundle for sort_seq: byte load port, start/status, and sorted-byte drain port.
// The master side is the producer/consumer that talks to the sorter.
interface sort_seq_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       start;
   logic       busy;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       done;
   logic [7:0] compares;

   modport master (
      output in_valid, in_data, start, out_ready,
      input  in_ready, busy, out_valid, out_data, done, compares
   );

   modport slave (
      input  in_valid, in_data, start, out_ready,
      output in_ready, busy, out_valid, out_data, done, compares
   );
endinterface

// File: rtl/sort_seq.sv
// In-place ascending bubble sorter over a small byte buffer, one compare-and-swap per clock
// through a single shared eightbit_comp, with early exit on a clean pass.
module eightbit_comp (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic       gt_o,
   output logic       eq_o,
   output logic       lt_o
);
   assign gt_o = (a_i >  b_i);
   assign eq_o = (a_i == b_i);
   assign lt_o = (a_i <  b_i);
endmodule

module sort_seq #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   sort_seq_if.slave  bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_e;

   state_e        state_q;
   logic [7:0]    mem_q [DEPTH];
   logic [CW-1:0] count_q;
   logic [CW-1:0] limit_q;
   logic [AW-1:0] i_q;
   logic [AW-1:0] rd_ptr_q;
   logic          swapped_q;
   logic          done_q;
   logic [7:0]    compares_q;

   logic [AW-1:0] i1;
   logic          wr_en;
   logic [CW-1:0] count_d;
   logic          cmp_gt, cmp_eq, cmp_lt;
   logic          swap_en;
   logic          pass_end;
   logic          rd_last;
   logic          xfer;

   assign i1 = i_q + AW'(1);

   eightbit_comp u_cmp (
      .a_i  (mem_q[i_q]),
      .b_i  (mem_q[i1]),
      .gt_o (cmp_gt),
      .eq_o (cmp_eq),
      .lt_o (cmp_lt)
   );

   // Strictly-greater only: equal keys must never move, which keeps the sort stable.
   assign swap_en  = cmp_gt & ~(cmp_eq | cmp_lt);

   assign bus.in_ready  = (state_q == LOAD) && (count_q < CW'(DEPTH));
   assign bus.out_valid = (state_q == DRAIN);
   assign bus.busy      = (state_q == SORT) || (state_q == DRAIN);
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.done      = done_q;
   assign bus.compares  = compares_q;

   assign wr_en    = bus.in_valid & bus.in_ready;
   assign count_d  = count_q + CW'(wr_en);
   assign pass_end = (CW'(i_q) == limit_q - CW'(1));
   assign rd_last  = (CW'(rd_ptr_q) == count_q - CW'(1));
   assign xfer     = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= LOAD;
         count_q    <= '0;
         limit_q    <= '0;
         i_q        <= '0;
         rd_ptr_q   <= '0;
         swapped_q  <= 1'b0;
         done_q     <= 1'b0;
         compares_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (wr_en) mem_q[count_q[AW-1:0]] <= bus.in_data;
               count_q <= count_d;
               // A byte written alongside start is part of the batch.
               if (bus.start && count_d == CW'(1)) begin
                  state_q    <= DRAIN;
                  compares_q <= '0;
               end else if (bus.start && count_d >= CW'(2)) begin
                  state_q    <= SORT;
                  i_q        <= '0;
                  limit_q    <= count_d - CW'(1);
                  swapped_q  <= 1'b0;
                  compares_q <= '0;
               end
            end
            SORT: begin
               if (swap_en) begin
                  mem_q[i_q] <= mem_q[i1];
                  mem_q[i1]  <= mem_q[i_q];
               end
               if (compares_q != 8'hFF) compares_q <= compares_q + 8'd1;
               if (!pass_end) begin
                  i_q       <= i1;
                  swapped_q <= swapped_q | swap_en;
               end else if (!(swapped_q | swap_en) || limit_q == CW'(1)) begin
                  state_q <= DRAIN;
               end else begin
                  limit_q   <= limit_q - CW'(1);
                  i_q       <= '0;
                  swapped_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (xfer) begin
                  if (rd_last) begin
                     state_q  <= LOAD;
                     count_q  <= '0;
                     rd_ptr_q <= '0;
                     done_q   <= 1'b1;
                  end else begin
                     rd_ptr_q <= rd_ptr_q + AW'(1);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_sort_seq.sv
// Directed bench for sort_seq: hand-computed sort results, compare counts, handshake and reset cases.
module tb_sort_seq;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   sort_seq_if bus ();

   sort_seq #(.DEPTH(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bq_t v);
      foreach (v[j]) begin
         bus.in_valid = 1'b1;
         bus.in_data  = v[j];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_sort(output int sc, output logic rdy_bad);
      sc = 0;
      rdy_bad = 1'b0;
      while (bus.busy && !bus.out_valid && sc < 300) begin
         if (bus.in_ready) rdy_bad = 1'b1;
         sc++;
         tick();
      end
   endtask

   task automatic drain(input bq_t exp, input bit bp);
      int         k = 0;
      int         cyc = 0;
      logic [7:0] held = '0;
      bit         hold_chk = 1'b0;
      while (k < exp.size() && cyc < 200) begin
         bus.out_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
         chk("out_valid", bus.out_valid, 1'b1);
         if (hold_chk) chk("hold", bus.out_data, held);
         if (bus.out_ready) begin
            chk($sformatf("byte%0d", k), bus.out_data, exp[k]);
            k++;
            hold_chk = 1'b0;
         end else begin
            held = bus.out_data;
            hold_chk = 1'b1;
         end
         tick();
         cyc++;
      end
      bus.out_ready = 1'b0;
      chk("delivered", k, exp.size());
      if (!bp) chk("drain_cycles", cyc, exp.size());
      chk("done", bus.done, 1'b1);
      chk("rdy_after", bus.in_ready, 1'b1);
      chk("busy_after", bus.busy, 1'b0);
      tick();
      chk("done_pulse", bus.done, 1'b0);
   endtask

   task automatic run(input bq_t din, input bq_t dexp, input int exp_cmp, input bit bp);
      int   sc;
      logic rdy_bad;
      load(din);
      if (din.size() == 8) chk("full_rdy", bus.in_ready, 1'b0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_sort(sc, rdy_bad);
      chk("sort_cycles", sc, exp_cmp);
      chk("compares", bus.compares, exp_cmp);
      chk("rdy_in_sort", rdy_bad, 1'b0);
      drain(dexp, bp);
      chk("compares_hold", bus.compares, exp_cmp);
   endtask

   task automatic reset_pulse_check(input string tag);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk({tag, "_rdy"}, bus.in_ready, 1'b1);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_ovld"}, bus.out_valid, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      tick();
      chk({tag, "_done2"}, bus.done, 1'b0);
   endtask

   initial begin
      bq_t din, dexp;
      int  t;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_rdy", bus.in_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ovld", bus.out_valid, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_cmp", bus.compares, 8'h00);
      rst = 1'b0;
      tick();

      // start with an empty buffer is ignored
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("empty_busy", bus.busy, 1'b0);
      chk("empty_rdy", bus.in_ready, 1'b1);

      din  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      dexp = din;
      run(din, dexp, 7, 1'b0);

      din  = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      dexp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run(din, dexp, 28, 1'b0);

      din  = '{8'hFF, 8'h00, 8'h80};
      dexp = '{8'h00, 8'h80, 8'hFF};
      run(din, dexp, 3, 1'b0);

      din  = '{8'h05, 8'h03, 8'h05, 8'h03};
      dexp = '{8'h03, 8'h03, 8'h05, 8'h05};
      run(din, dexp, 6, 1'b0);

      din  = '{8'h42};
      dexp = '{8'h42};
      run(din, dexp, 0, 1'b0);

      din  = '{8'h3C, 8'hA1, 8'h07, 8'hFF, 8'h00, 8'h5A, 8'h5A, 8'h80};
      dexp = '{8'h00, 8'h07, 8'h3C, 8'h5A, 8'h5A, 8'h80, 8'hA1, 8'hFF};
      run(din, dexp, 25, 1'b1);

      // reset in the middle of SORT
      din = '{8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      load(din);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      chk("midsort_busy", bus.busy, 1'b1);
      reset_pulse_check("rst_sort");

      // reset in the middle of DRAIN
      din = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      load(din);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t = 0;
      while (!bus.out_valid && t < 100) begin
         t++;
         tick();
      end
      chk("middrain_ovld", bus.out_valid, 1'b1);
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
      reset_pulse_check("rst_drain");

      din  = '{8'h7F, 8'h10};
      dexp = '{8'h10, 8'h7F};
      run(din, dexp, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/sort_seq.md
# sort_seq

Sequential byte sorter that reuses one `eightbit_comp` instance as its only magnitude comparator. It buffers up to DEPTH unsigned bytes and sorts them in place, ascending, with a bubble-sort sequencer: one compare-and-conditional-swap per clock, ending early once a pass makes no swap. It then streams the sorted bytes out over a valid/ready handshake. It is the first controller in the design to sequence the comparator datapath.

## Interface
- DEPTH, 8, buffer capacity in bytes; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `in_data` is offered.
- in_data  in  8  unsigned byte to load.
- in_ready  out  1  high in LOAD when count < DEPTH.
- start  in  1  begin sorting; sampled only in LOAD.
- busy  out  1  high in SORT and DRAIN.
- out_valid  out  1  high in DRAIN.
- out_data  out  8  current sorted byte, `mem[rd_ptr]`.
- out_ready  in  1  consumer accepts `out_data`.
- done  out  1  one-cycle pulse after the last byte is accepted.
- compares  out  8  number of compare cycles in the last sort; holds until the next start.

## Operation
- Reset: state=LOAD, count=0, rd_ptr=0, compares=0.
- Reset outputs: in_ready=1, busy=0, out_valid=0, done=0, out_data=mem[0] (don't-care).
- Buffer contents are not cleared on reset.

LOAD state:
- A write happens when in_valid and in_ready are both high: mem[count] ← in_data, count increments.
- start=1 with count=0 (counting any write in the same cycle) is ignored.
- start=1 with count=1 → DRAIN; compares=0.
- start=1 with count≥2 → SORT: i=0, limit=count−1, swapped=0, compares=0.
- A write in the same cycle as start is included in the sort.

SORT state (one cycle per compare):
- The comparator inputs are a=mem[i], b=mem[i+1].
- If gt: swap the two entries and set swapped.
- If eq or lt: no swap. Equal keys are never swapped, so the sort is stable.
- compares increments every SORT cycle and saturates at 255.
- If i < limit−1: i increments.
- At the end of a pass (i = limit−1):
  - If no swap occurred in the pass (the swap in this cycle counts) or limit=1 → DRAIN.
  - Otherwise limit decrements, i=0, swapped=0.
- in_valid and start are ignored; in_ready=0.

DRAIN state:
- out_valid=1 and out_data=mem[rd_ptr].
- A transfer happens when out_valid and out_ready are both high; rd_ptr then increments.
- While out_ready=0, out_data holds stable.
- On the transfer with rd_ptr=count−1:
  - next state LOAD, count=0, rd_ptr=0;
  - done=1 for the following cycle.

Other rules:
- All compares are unsigned 8-bit; there is no sign or width extension.
- rst has priority in every state. Reset during SORT or DRAIN discards the batch; the next cycle is LOAD with in_ready=1 and no done pulse.

## Timing
- in_ready, out_valid and busy are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- A start accepted at edge N puts the block in SORT in cycle N+1.
- SORT cycles for n bytes:
  - already-sorted input: n−1;
  - reverse-sorted input: n(n−1)/2, which is 28 for n=8;
  - otherwise: (sum of full passes) + (length of the final clean pass).
- The first out_valid is in the cycle after the last SORT cycle.
- The minimum drain is n cycles when out_ready is held high.
- done is asserted in the cycle the block re-enters LOAD; in_ready is already 1 in that cycle.
- compares becomes valid when DRAIN is entered.

## Test plan
- Sorted load 01..08, start → 7 SORT cycles, compares=7, outputs 01..08 on 8 consecutive cycles, done one cycle later.
- Reverse load 08..01 → compares=28, outputs 01..08.
- Partial load FF,00,80, then start → outputs 00,80,FF; in_ready stays 0 from start until done.
- Duplicate keys 05,03,05,03 → outputs 03,03,05,05; no swap is issued on any eq compare (check `eightbit_comp` eq vs swap enable).
- Output backpressure: toggle out_ready 1,0,0,1 during DRAIN of 8 bytes → out_data stable while out_ready=0; every byte delivered exactly once, in order.
- Reset mid-SORT and mid-DRAIN (8 bytes loaded) → next cycle in_ready=1, busy=0, out_valid=0, no done; then load 2 bytes 7F,10 → outputs 10,7F, compares=1.
